// File: rtl/addertree_pkg.sv
// rtl/addertree_pkg.sv - shared constants and elaboration helpers for the signed adder tree
package addertree_pkg;

   localparam logic MODE_SUM = 1'b0;
   localparam logic MODE_ACC = 1'b1;
   localparam int   COUNT_W  = 8;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int out_w(input int width, input int num, input int acc_bits);
      return width + clog2(num) + acc_bits;
   endfunction

   // Operands still in flight after a given number of pairwise levels.
   function automatic int level_count(input int num, input int level);
      int n;
      n = num;
      for (int i = 0; i < level; i++) begin
         n = (n + 1) / 2;
      end
      return n;
   endfunction

endpackage

// File: rtl/addertree_level.sv
// rtl/addertree_level.sv - one registered pairwise-add level with hold enable
module addertree_level #(
   parameter  int N_IN  = 7,
   parameter  int W_IN  = 17,
   localparam int N_OUT = (N_IN + 1) / 2,
   localparam int W_OUT = W_IN + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_IN*W_IN-1:0]   in_data,
   input  logic                   in_valid,
   input  logic                   in_mode,
   input  logic                   in_last,
   output logic [N_OUT*W_OUT-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_mode,
   output logic                   out_last
);

   function automatic logic [W_OUT-1:0] sext(input logic [W_IN-1:0] v);
      return {v[W_IN-1], v};
   endfunction

   logic [N_OUT*W_OUT-1:0] sum;

   // One extra bit per level keeps every pairwise sum exact.
   always_comb begin
      sum = '0;
      for (int k = 0; k < N_IN / 2; k++) begin
         sum[k*W_OUT +: W_OUT] = sext(in_data[2*k*W_IN +: W_IN])
                               + sext(in_data[(2*k+1)*W_IN +: W_IN]);
      end
      if (N_IN % 2 == 1) begin
         sum[(N_OUT-1)*W_OUT +: W_OUT] = sext(in_data[(N_IN-1)*W_IN +: W_IN]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_last  <= 1'b0;
      end else if (en) begin
         out_data  <= sum;
         out_valid <= in_valid;
         out_mode  <= in_mode;
         out_last  <= in_last;
      end
   end

endmodule

// File: rtl/pipelined_signed_addertree.sv
// rtl/pipelined_signed_addertree.sv - pipelined signed adder tree with frame accumulator
module pipelined_signed_addertree
   import addertree_pkg::*;
#(
   parameter  int WIDTH    = 17,
   parameter  int NUM      = 7,
   parameter  int ACC_BITS = 8,
   localparam int L        = clog2(NUM),
   localparam int OUT_W    = out_w(WIDTH, NUM, ACC_BITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM*WIDTH-1:0]    in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic                    in_last,
   output logic signed [OUT_W-1:0] out_data,
   output logic [COUNT_W-1:0]      out_count,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int TREE_W = WIDTH + L;

   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   logic [NUM*WIDTH-1:0] s0_data;
   logic                 s0_valid;
   logic                 s0_mode;
   logic                 s0_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_data  <= '0;
         s0_valid <= 1'b0;
         s0_mode  <= 1'b0;
         s0_last  <= 1'b0;
      end else if (en) begin
         s0_data  <= in_data;
         s0_valid <= in_valid;
         s0_mode  <= in_mode;
         s0_last  <= in_last;
      end
   end

   for (genvar i = 0; i < L; i++) begin : g_lvl
      localparam int NI = level_count(NUM, i);
      localparam int WI = WIDTH + i;
      localparam int NO = (NI + 1) / 2;

      logic [NI*WI-1:0]     d_in;
      logic                 v_in, m_in, l_in;
      logic [NO*(WI+1)-1:0] d_out;
      logic                 v_out, m_out, l_out;

      if (i == 0) begin : g_head
         assign d_in = s0_data;
         assign v_in = s0_valid;
         assign m_in = s0_mode;
         assign l_in = s0_last;
      end else begin : g_chain
         assign d_in = g_lvl[i-1].d_out;
         assign v_in = g_lvl[i-1].v_out;
         assign m_in = g_lvl[i-1].m_out;
         assign l_in = g_lvl[i-1].l_out;
      end

      addertree_level #(
         .N_IN (NI),
         .W_IN (WI)
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .in_data   (d_in),
         .in_valid  (v_in),
         .in_mode   (m_in),
         .in_last   (l_in),
         .out_data  (d_out),
         .out_valid (v_out),
         .out_mode  (m_out),
         .out_last  (l_out)
      );
   end

   logic [TREE_W-1:0]  tree;
   logic [OUT_W-1:0]   sum_ext;
   logic [OUT_W-1:0]   acc;
   logic [COUNT_W-1:0] cnt;
   logic [COUNT_W-1:0] cnt_inc;

   assign tree    = g_lvl[L-1].d_out;
   assign sum_ext = OUT_W'($signed(tree));
   assign cnt_inc = (cnt == {COUNT_W{1'b1}}) ? cnt : cnt + COUNT_W'(1);

   // A mode-0 beat or a frame's last beat emits a result and restarts the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
      end else if (en) begin
         out_valid <= 1'b0;
         if (g_lvl[L-1].v_out) begin
            if (g_lvl[L-1].m_out == MODE_SUM) begin
               out_data  <= sum_ext;
               out_count <= COUNT_W'(1);
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else if (g_lvl[L-1].l_out) begin
               out_data  <= acc + sum_ext;
               out_count <= cnt_inc;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= acc + sum_ext;
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_signed_addertree.sv
// tb/tb_pipelined_signed_addertree.sv - scoreboard bench for the pipelined signed adder tree
module tb_pipelined_signed_addertree;

   localparam int W  = 17;
   localparam int N  = 7;
   localparam int OW = 28;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N*W-1:0]        in_data = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  in_mode = 1'b0;
   logic                  in_last = 1'b0;
   logic signed [OW-1:0]  out_data;
   logic [7:0]            out_count;
   logic                  out_valid;
   logic                  out_ready = 1'b1;

   logic [7:0]            s_in_data = '0;
   logic                  s_in_valid = 1'b0;
   logic                  s_in_ready;
   logic signed [12:0]    s_out_data;
   logic [7:0]            s_out_count;
   logic                  s_out_valid;

   pipelined_signed_addertree dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_data  (out_data),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   pipelined_signed_addertree #(.WIDTH(4), .NUM(2), .ACC_BITS(8)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_mode   (1'b0),
      .in_last   (1'b0),
      .out_data  (s_out_data),
      .out_count (s_out_count),
      .out_valid (s_out_valid),
      .out_ready (1'b1)
   );

   typedef struct {
      logic [OW-1:0] d;
      logic [7:0]    c;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [OW-1:0] m_acc = '0;
   int            m_cnt = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: out_data=%0d out_count=%0d, required no output",
                     out_data, out_count);
         end else begin
            mon_e = sb.pop_front();
            if (out_data !== mon_e.d || out_count !== mon_e.c) begin
               errors++;
               $display("FAIL scoreboard: out_data=%0d out_count=%0d, expected out_data=%0d out_count=%0d",
                        out_data, out_count, $signed(mon_e.d), mon_e.c);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) d[k*W +: W] = v;
      return d;
   endfunction

   task automatic model_reset();
      sb.delete();
      m_acc = '0;
      m_cnt = 0;
   endtask

   task automatic send(input logic [N*W-1:0] d, input logic mode, input logic last);
      logic   r;
      int     t;
      longint s;
      exp_t   e;
      in_data  = d;
      in_mode  = mode;
      in_last  = last;
      in_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!r && t < 200);
      in_valid = 1'b0;
      if (!r) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", t);
         return;
      end
      s = 0;
      for (int k = 0; k < N; k++) s += longint'($signed(d[k*W +: W]));
      if (mode == 1'b0) begin
         e.d = OW'(s);
         e.c = 8'd1;
         sb.push_back(e);
         m_acc = '0;
         m_cnt = 0;
      end else begin
         m_acc = m_acc + OW'(s);
         if (m_cnt < 255) m_cnt++;
         if (last) begin
            e.d = m_acc;
            e.c = 8'(m_cnt);
            sb.push_back(e);
            m_acc = '0;
            m_cnt = 0;
         end
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: out_valid=%b s_out_valid=%b, required 0 0", out_valid, s_out_valid);
      end
      checks++;
      if (out_data !== '0 || out_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_data: out_data=%0d out_count=%0d, required 0 0", out_data, out_count);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_sum_positive();
      int lat;
      send(fill(17'h0FFFF), 1'b0, 1'b0);
      wait_valid(lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL pos_latency: %0d cycles, required 4", lat);
      end
      checks++;
      if (out_data !== 28'sd458745 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL pos_sum: out_data=%0d out_count=%0d, required 458745 1", out_data, out_count);
      end
      drain();
   endtask

   task automatic test_sum_negative();
      int lat;
      send(fill(17'h10000), 1'b0, 1'b0);
      wait_valid(lat);
      checks++;
      if (out_data !== -28'sd458752 || out_data[19:0] !== 20'h90000 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL neg_sum: out_data=%0d out_count=%0d, required -458752 1", out_data, out_count);
      end
      drain();
   endtask

   task automatic test_frame();
      int lat;
      send(fill(17'd1), 1'b1, 1'b0);
      send(fill(17'd1), 1'b1, 1'b0);
      send(fill(17'd1), 1'b1, 1'b1);
      wait_valid(lat);
      checks++;
      if (out_data !== 28'sd21 || out_count !== 8'd3) begin
         errors++;
         $display("FAIL frame_sum: out_data=%0d out_count=%0d, required 21 3", out_data, out_count);
      end
      drain();
   endtask

   task automatic test_saturate_wrap();
      int     lat;
      longint big;
      for (int b = 0; b < 600; b++) send(fill(17'h0FFFF), 1'b1, b == 599);
      wait_valid(lat);
      big = longint'(600) * 458745;
      checks++;
      if (out_data !== OW'(big) || out_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_wrap: out_data=%0d out_count=%0d, required %0d 255",
                  out_data, out_count, $signed(OW'(big)));
      end
      drain();
   endtask

   task automatic test_stall();
      logic [N*W-1:0]       d;
      logic signed [OW-1:0] held;
      fork
         begin
            for (int b = 0; b < 12; b++) begin
               for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
               send(d, 1'b0, 1'b0);
            end
         end
         begin
            repeat (6) @(posedge clk);
            #2;
            out_ready = 1'b0;
            @(negedge clk);
            held = out_data;
            for (int i = 0; i < 5; i++) begin
               checks++;
               if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                  errors++;
                  $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b out_data=%0d, required 0 1 %0d",
                           i, in_ready, out_valid, out_data, held);
               end
               if (i < 4) @(negedge clk);
            end
            @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL stall_drain: %0d results missing, required 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int start;
      start = cyc;
      for (int b = 0; b < 8; b++) send(fill(W'(b * 1000 - 3000)), 1'b0, 1'b0);
      checks++;
      if (cyc - start !== 8) begin
         errors++;
         $display("FAIL b2b_rate: %0d cycles for 8 beats, required 8", cyc - start);
      end
      drain();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: %0d results missing, required 0", sb.size());
      end
   endtask

   task automatic test_reset_midframe();
      int lat;
      send(fill(17'd5), 1'b1, 1'b0);
      send(fill(17'd5), 1'b1, 1'b0);
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(fill(17'd2), 1'b0, 1'b0);
      wait_valid(lat);
      checks++;
      if (out_data !== 28'sd14 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL rst_mid_pipe: out_data=%0d out_count=%0d, required 14 1", out_data, out_count);
      end
      drain();
      send(fill(17'd3), 1'b1, 1'b0);
      send(fill(17'd3), 1'b1, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(fill(17'd2), 1'b1, 1'b1);
      wait_valid(lat);
      checks++;
      if (out_data !== 28'sd14 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL rst_mid_frame: out_data=%0d out_count=%0d, required 14 1", out_data, out_count);
      end
      drain();
   endtask

   task automatic test_small();
      int lat;
      s_in_data  = {4'h8, 4'h8};
      s_in_valid = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL small_latency: %0d cycles, required 2", lat);
      end
      checks++;
      if (s_out_data !== -13'sd16 || s_out_count !== 8'd1) begin
         errors++;
         $display("FAIL small_sum: out_data=%0d out_count=%0d, required -16 1", s_out_data, s_out_count);
      end
   endtask

   initial begin
      test_reset();
      test_sum_positive();
      test_sum_negative();
      test_frame();
      test_saturate_wrap();
      test_stall();
      test_back_to_back();
      test_reset_midframe();
      test_small();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_drain: %0d results outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
